// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO memory and its burst reader.
package fifo_pkg;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/fifo_skid_buf.sv
// Two-entry skid buffer: absorbs words whose FIFO read was already issued
// when the consumer stalls. The head register drives m_data directly.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             m_ready,
  output logic             pop,
  output logic [1:0]       occ,
  output logic             m_valid,
  output logic [WIDTH-1:0] m_data
);

  logic [WIDTH-1:0] head_reg;
  logic [WIDTH-1:0] tail_reg;
  logic [1:0]       occ_reg;

  assign m_valid = (occ_reg != 2'd0);
  assign pop     = m_valid & m_ready;
  assign occ     = occ_reg;
  assign m_data  = head_reg;

  // Shift words toward the head; a push into a full buffer without a pop is dropped defensively.
  always_ff @(posedge clk) begin
    if (!reset) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_reg == 2'd0) begin
            head_reg <= push_data;
            occ_reg  <= 2'd1;
          end else if (occ_reg == 2'd1) begin
            tail_reg <= push_data;
            occ_reg  <= 2'd2;
          end
        end
        2'b01: begin
          head_reg <= tail_reg;
          occ_reg  <= occ_reg - 2'd1;
        end
        2'b11: begin
          if (occ_reg == 2'd1) begin
            head_reg <= push_data;
          end else begin
            head_reg <= tail_reg;
            tail_reg <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Burst read master for the cs/rd/empty/dataOut FIFO. Issues reads only when
// the skid buffer is guaranteed room for the word still in flight.
module fifo_burst_reader
  import fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int CNT_W = FIFO_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] rd_count,
  output logic             fifo_cs,
  output logic             fifo_rd,
  input  logic             fifo_empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [WIDTH-1:0] m_data
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] remaining_reg;
  logic [CNT_W-1:0] rd_count_reg;
  logic             inflight_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             rd_ok;
  logic             pop;
  logic [1:0]       occ;
  logic [2:0]       fill;
  logic [2:0]       room;

  // Words held plus the one arriving must stay within two after this cycle's pop.
  assign fill  = {1'b0, occ} + {2'b00, inflight_reg};
  assign room  = 3'd2 + {2'b00, pop};
  assign rd_ok = (state_reg == READ) && (remaining_reg != '0) && !fifo_empty && (fill < room);

  assign busy     = busy_reg;
  assign done     = done_reg;
  assign rd_count = rd_count_reg;
  assign fifo_cs  = fifo_rd;

  fifo_skid_buf #(.WIDTH(WIDTH)) u_skid (
    .clk       (clk),
    .reset     (reset),
    .push      (inflight_reg),
    .push_data (fifo_data),
    .m_ready   (m_ready),
    .pop       (pop),
    .occ       (occ),
    .m_valid   (m_valid),
    .m_data    (m_data)
  );

  // State register; busy/done are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // Next-state logic; DRAIN exits as soon as the final word is handed over this cycle.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = (burst_len == '0) ? DONE : READ;
      end
      READ: begin
        if (rd_ok && (remaining_reg == {{(CNT_W-1){1'b0}}, 1'b1})) state_next = DRAIN;
      end
      DRAIN: begin
        if (!inflight_reg && ((occ == 2'd0) || ((occ == 2'd1) && pop))) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: read strobe is live, status flags follow the next state.
  always_comb begin
    fifo_rd   = rd_ok;
    busy_next = (state_next == READ) || (state_next == DRAIN);
    done_next = (state_next == DONE);
  end

  // Burst counters and the one-cycle read-latency tracker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      remaining_reg <= '0;
      rd_count_reg  <= '0;
      inflight_reg  <= 1'b0;
    end else begin
      inflight_reg <= fifo_rd;
      if ((state_reg == IDLE) && start) begin
        remaining_reg <= burst_len;
        rd_count_reg  <= '0;
      end else if (fifo_rd) begin
        remaining_reg <= remaining_reg - 1'b1;
        rd_count_reg  <= rd_count_reg + 1'b1;
      end
    end
  end

endmodule
